// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART transmitter among NUM_REQ message sources.
// Each granted 1- or 2-byte message is latched and fed byte by byte (low byte first) into the TX parallel port.
module uart_tx_sched #(
  parameter int NUM_REQ = 2,
  parameter int BUSY_TO = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_REQ-1:0]    REQ,
  input  logic [16*NUM_REQ-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]    REQ_LEN,
  output logic [NUM_REQ-1:0]    GRANT,
  output logic [NUM_REQ-1:0]    DONE,
  output logic [7:0]            TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_BUSY,
  output logic                  TX_ERR,
  output logic                  SCHED_BUSY
);
  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] TO_LAST = 8'(BUSY_TO - 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_HI, WAIT_LO, FIN} state_t;

  state_t             state_reg, state_next;
  logic [LW-1:0]      last_reg, last_next;
  logic [15:0]        msg_reg, msg_next;
  logic               len_reg, len_next;
  logic               idx_reg, idx_next;
  logic [7:0]         cnt_reg, cnt_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic [7:0]         pdata_reg, pdata_next;
  logic               vld_reg, vld_next;
  logic               err_reg, err_next;
  logic               sbusy_reg, sbusy_next;

  logic [LW-1:0]      winner;
  logic [NUM_REQ-1:0] win_onehot;
  logic [15:0]        win_data;
  logic               win_len;
  logic               found;
  logic               more_bytes;

  // First requester after last_reg, wrapping around.
  always_comb begin
    winner = last_reg;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && REQ[j] &&
            ((int'(last_reg) + k == j) || (int'(last_reg) + k == j + NUM_REQ))) begin
          found  = 1'b1;
          winner = LW'(j);
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign win_onehot[gi] = (winner == LW'(gi));
    end
  endgenerate

  always_comb begin
    win_data = '0;
    win_len  = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (winner == LW'(j)) begin
        win_data = REQ_DATA[16*j +: 16];
        win_len  = REQ_LEN[j];
      end
    end
  end

  assign more_bytes = len_reg && !idx_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|REQ) state_next = LOAD;
      LOAD:    if (!TX_BUSY) state_next = WAIT_HI;
      WAIT_HI: begin
        if (TX_BUSY)                  state_next = WAIT_LO;
        else if (cnt_reg == TO_LAST)  state_next = FIN;
      end
      WAIT_LO: if (!TX_BUSY) state_next = more_bytes ? LOAD : FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of every registered output; DONE and the GRANT clear land together on entry to FIN.
  always_comb begin
    last_next  = last_reg;
    msg_next   = msg_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    grant_next = grant_reg;
    pdata_next = pdata_reg;
    done_next  = '0;
    vld_next   = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|REQ) begin
          grant_next = win_onehot;
          last_next  = winner;
          msg_next   = win_data;
          len_next   = win_len;
          idx_next   = 1'b0;
        end
      end
      LOAD: begin
        if (!TX_BUSY) begin
          pdata_next = idx_reg ? msg_reg[15:8] : msg_reg[7:0];
          vld_next   = 1'b1;
          cnt_next   = '0;
        end
      end
      WAIT_HI: begin
        if (!TX_BUSY) begin
          if (cnt_reg == TO_LAST) begin
            err_next   = 1'b1;
            done_next  = grant_reg;
            grant_next = '0;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
      WAIT_LO: begin
        if (!TX_BUSY) begin
          if (more_bytes) begin
            idx_next = 1'b1;
          end else begin
            done_next  = grant_reg;
            grant_next = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign sbusy_next = (state_next != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_reg  <= LW'(NUM_REQ - 1);
      msg_reg   <= '0;
      len_reg   <= 1'b0;
      idx_reg   <= 1'b0;
      cnt_reg   <= '0;
      grant_reg <= '0;
      done_reg  <= '0;
      pdata_reg <= '0;
      vld_reg   <= 1'b0;
      err_reg   <= 1'b0;
      sbusy_reg <= 1'b0;
    end else begin
      last_reg  <= last_next;
      msg_reg   <= msg_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
      done_reg  <= done_next;
      pdata_reg <= pdata_next;
      vld_reg   <= vld_next;
      err_reg   <= err_next;
      sbusy_reg <= sbusy_next;
    end
  end

  assign GRANT      = grant_reg;
  assign DONE       = done_reg;
  assign TX_P_DATA  = pdata_reg;
  assign TX_D_VLD   = vld_reg;
  assign TX_ERR     = err_reg;
  assign SCHED_BUSY = sbusy_reg;
endmodule
